// File: rtl/reg_file_pkg.sv
// Shared defaults and address/data types for the parametrised register file.
package reg_file_pkg;

    localparam int unsigned DEF_DW       = 8;
    localparam int unsigned DEF_NREG     = 8;
    localparam int unsigned DEF_MAX_PEND = 2;
    localparam int unsigned DEF_AW       = $clog2(DEF_NREG);

    typedef logic [DEF_AW-1:0] reg_addr_t;
    typedef logic [DEF_DW-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard for outstanding loads: busy vector, pending counter,
// full flag and sticky protocol-error flag.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NREG     = DEF_NREG,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned MAX_PEND = DEF_MAX_PEND,
    parameter int unsigned PW       = $clog2(MAX_PEND + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_i,
    input  logic [AW-1:0]   set_addr_i,
    input  logic            clr_i,
    input  logic [AW-1:0]   clr_addr_i,
    output logic [NREG-1:0] busy_o,
    output logic [PW-1:0]   pend_o,
    output logic            pend_full_o,
    output logic            err_o
);

    logic [NREG-1:0] busy_q, busy_d, busy_after_clr;
    logic [PW-1:0]   pend_q, pend_d;
    logic            err_q, err_d;
    logic            clr_ok, clr_bad, set_ok, set_bad;

    assign pend_full_o = (pend_q == PW'(MAX_PEND));

    // The clear is applied before the set is judged, so a set to the address
    // being returned this cycle is accepted (net busy 1, PEND unchanged).
    always_comb begin
        busy_after_clr = busy_q;
        clr_ok         = clr_i && busy_q[clr_addr_i];
        clr_bad        = clr_i && !busy_q[clr_addr_i];
        if (clr_ok) begin
            busy_after_clr[clr_addr_i] = 1'b0;
        end
        set_ok  = set_i && !pend_full_o && !busy_after_clr[set_addr_i];
        set_bad = set_i && !set_ok;

        busy_d = busy_after_clr;
        if (set_ok) begin
            busy_d[set_addr_i] = 1'b1;
        end

        pend_d = pend_q;
        case ({set_ok, clr_ok})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase

        err_d = err_q | clr_bad | set_bad;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign pend_o = pend_q;
    assign err_o  = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with ALU write port, handshaked load-return port, load
// scoreboard and debug read port. Define REG_FILE_BYPASS_EN for write-first reads.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned NREG     = DEF_NREG,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned MAX_PEND = DEF_MAX_PEND
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [AW-1:0]                 RA1,
    input  logic [AW-1:0]                 RA2,
    output logic [DW-1:0]                 RD1,
    output logic [DW-1:0]                 RD2,
    output logic                          BUSY1,
    output logic                          BUSY2,
    input  logic                          WE3,
    input  logic [AW-1:0]                 WA3,
    input  logic [DW-1:0]                 WD3,
    input  logic                          LD_VALID,
    output logic                          LD_RDY,
    input  logic [AW-1:0]                 LD_WA,
    input  logic [DW-1:0]                 LD_WD,
    input  logic                          SB_SET,
    input  logic [AW-1:0]                 SB_WA,
    output logic [$clog2(MAX_PEND+1)-1:0] PEND,
    output logic                          PEND_FULL,
    output logic                          ERR,
    input  logic [AW-1:0]                 DBG_RA,
    output logic [DW-1:0]                 DBG_RD
);

    localparam int unsigned PW = $clog2(MAX_PEND + 1);

    logic [NREG-1:0][DW-1:0] rf_q, rf_d;
    logic [NREG-1:0]         busy;
    logic                    ld_fire;

    // A same-address ALU write takes the cycle; the load retries next cycle.
    assign LD_RDY  = !(WE3 && (WA3 == LD_WA));
    assign ld_fire = LD_VALID && LD_RDY;

    always_comb begin
        rf_d = rf_q;
        if (WE3) begin
            rf_d[WA3] = WD3;
        end
        if (ld_fire) begin
            rf_d[LD_WA] = LD_WD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_q <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    reg_file_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .MAX_PEND (MAX_PEND),
        .PW       (PW)
    ) u_scoreboard (
        .clk_i       (CLK),
        .rst_i       (RST),
        .set_i       (SB_SET),
        .set_addr_i  (SB_WA),
        .clr_i       (ld_fire),
        .clr_addr_i  (LD_WA),
        .busy_o      (busy),
        .pend_o      (PEND),
        .pend_full_o (PEND_FULL),
        .err_o       (ERR)
    );

`ifdef REG_FILE_BYPASS_EN
    // ALU forwarding first; a colliding load cannot fire in the same cycle.
    assign RD1    = (WE3 && (RA1 == WA3))        ? WD3 :
                    (ld_fire && (RA1 == LD_WA))  ? LD_WD : rf_q[RA1];
    assign RD2    = (WE3 && (RA2 == WA3))        ? WD3 :
                    (ld_fire && (RA2 == LD_WA))  ? LD_WD : rf_q[RA2];
    assign DBG_RD = (WE3 && (DBG_RA == WA3))     ? WD3 :
                    (ld_fire && (DBG_RA == LD_WA)) ? LD_WD : rf_q[DBG_RA];
    assign BUSY1  = busy[RA1] && !(ld_fire && (LD_WA == RA1));
    assign BUSY2  = busy[RA2] && !(ld_fire && (LD_WA == RA2));
`else
    assign RD1    = rf_q[RA1];
    assign RD2    = rf_q[RA2];
    assign DBG_RD = rf_q[DBG_RA];
    assign BUSY1  = busy[RA1];
    assign BUSY2  = busy[RA2];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios then constrained-random
// traffic, each cycle's expected outputs queued and checked by a monitor.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int unsigned DW       = 8;
    localparam int unsigned NREG     = 8;
    localparam int unsigned AW       = 3;
    localparam int unsigned MAX_PEND = 2;
    localparam int unsigned PW       = 2;

    logic          CLK = 1'b0;
    logic          RST;
    reg_addr_t     RA1, RA2, WA3, LD_WA, SB_WA, DBG_RA;
    reg_data_t     WD3, LD_WD, RD1, RD2, DBG_RD;
    logic          WE3, LD_VALID, LD_RDY, SB_SET, BUSY1, BUSY2, PEND_FULL, ERR;
    logic [PW-1:0] PEND;

    reg_file_sb #(
        .DW       (DW),
        .NREG     (NREG),
        .AW       (AW),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .CLK(CLK), .RST(RST), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .WE3(WE3), .WA3(WA3), .WD3(WD3),
        .LD_VALID(LD_VALID), .LD_RDY(LD_RDY), .LD_WA(LD_WA), .LD_WD(LD_WD),
        .SB_SET(SB_SET), .SB_WA(SB_WA), .PEND(PEND), .PEND_FULL(PEND_FULL),
        .ERR(ERR), .DBG_RA(DBG_RA), .DBG_RD(DBG_RD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int        cyc;
        reg_data_t rd1, rd2, dbg;
        logic      b1, b2, rdy, full, err;
        int        pend;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state
    reg_data_t m_mem [NREG];
    bit        m_busy[NREG];
    int        m_pend;
    bit        m_err;

    function automatic bit m_ld_accepts();
        return LD_VALID && !(WE3 && (WA3 == LD_WA));
    endfunction

    function automatic reg_data_t m_read(input reg_addr_t a);
`ifdef REG_FILE_BYPASS_EN
        if (WE3 && a == WA3) return WD3;
        if (m_ld_accepts() && a == LD_WA) return LD_WD;
`endif
        return m_mem[a];
    endfunction

    function automatic bit m_busy_rd(input reg_addr_t a);
`ifdef REG_FILE_BYPASS_EN
        if (m_ld_accepts() && a == LD_WA) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic push_exp();
        exp_t e;
        e.cyc  = cyc;
        e.rd1  = m_read(RA1);
        e.rd2  = m_read(RA2);
        e.dbg  = m_read(DBG_RA);
        e.b1   = m_busy_rd(RA1);
        e.b2   = m_busy_rd(RA2);
        e.rdy  = !(WE3 && (WA3 == LD_WA));
        e.pend = m_pend;
        e.full = (m_pend == MAX_PEND);
        e.err  = m_err;
        q.push_back(e);
    endtask

    task automatic model_step();
        bit accept, was_full;
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_pend = 0;
            m_err  = 1'b0;
        end else begin
            accept   = m_ld_accepts();
            was_full = (m_pend == MAX_PEND);
            if (WE3) m_mem[WA3] = WD3;
            if (accept) begin
                m_mem[LD_WA] = LD_WD;
                if (m_busy[LD_WA]) begin
                    m_busy[LD_WA] = 1'b0;
                    m_pend--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (SB_SET) begin
                if (was_full || m_busy[SB_WA]) begin
                    m_err = 1'b1;
                end else begin
                    m_busy[SB_WA] = 1'b1;
                    m_pend++;
                end
            end
        end
    endtask

    task automatic tick();
        if (!RST) push_exp();
        @(posedge CLK);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic idle();
        RST = 1'b0; WE3 = 1'b0; LD_VALID = 1'b0; SB_SET = 1'b0;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("RD1",       e.cyc, 32'(RD1),       32'(e.rd1));
            chk("RD2",       e.cyc, 32'(RD2),       32'(e.rd2));
            chk("DBG_RD",    e.cyc, 32'(DBG_RD),    32'(e.dbg));
            chk("BUSY1",     e.cyc, 32'(BUSY1),     32'(e.b1));
            chk("BUSY2",     e.cyc, 32'(BUSY2),     32'(e.b2));
            chk("LD_RDY",    e.cyc, 32'(LD_RDY),    32'(e.rdy));
            chk("PEND",      e.cyc, 32'(PEND),      32'(e.pend));
            chk("PEND_FULL", e.cyc, 32'(PEND_FULL), 32'(e.full));
            chk("ERR",       e.cyc, 32'(ERR),       32'(e.err));
        end
    end

    initial begin
        bit stall;
        RA1 = '0; RA2 = '0; WA3 = '0; LD_WA = '0; SB_WA = '0; DBG_RA = '0;
        WD3 = '0; LD_WD = '0;
        idle();
        RST = 1'b1;
        tick(); tick();
        idle();

        // Reset clears a previously written register
        WE3 = 1'b1; WA3 = 3'd3; WD3 = 8'hAA; RA1 = 3'd3; DBG_RA = 3'd3;
        tick(); idle(); tick();
        RST = 1'b1; tick(); idle(); tick();

        // ALU write
        WE3 = 1'b1; WA3 = 3'd5; WD3 = 8'h3C; RA1 = 3'd5; RA2 = 3'd5;
        tick(); idle(); tick();

        // Load flow
        SB_SET = 1'b1; SB_WA = 3'd2; RA1 = 3'd2;
        tick(); idle(); tick();
        LD_VALID = 1'b1; LD_WA = 3'd2; LD_WD = 8'h7E;
        tick(); idle(); tick();

        // Collision: ALU wins, load completes a cycle later
        WE3 = 1'b1; WA3 = 3'd4; WD3 = 8'h11;
        LD_VALID = 1'b1; LD_WA = 3'd4; LD_WD = 8'h22; RA1 = 3'd4; RA2 = 3'd4;
        tick(); WE3 = 1'b0; tick(); idle(); tick();
        RST = 1'b1; tick(); idle();

        // Pending overflow
        SB_SET = 1'b1; SB_WA = 3'd1; tick();
        SB_WA = 3'd2; RA1 = 3'd2; tick();
        SB_WA = 3'd3; RA1 = 3'd3; RA2 = 3'd1; tick();
        idle(); tick(); tick();
        RST = 1'b1; tick(); idle();

        // Same-address set and clear
        SB_SET = 1'b1; SB_WA = 3'd6; RA1 = 3'd6; tick();
        LD_VALID = 1'b1; LD_WA = 3'd6; LD_WD = 8'h5A; tick();
        idle(); tick(); tick();

        // Random traffic honouring the hold-while-stalled rule
        stall = 1'b0;
        for (int n = 0; n < 600; n++) begin
            RST    = ($urandom_range(0, 63) == 0);
            RA1    = AW'($urandom_range(0, NREG-1));
            RA2    = AW'($urandom_range(0, NREG-1));
            DBG_RA = AW'($urandom_range(0, NREG-1));
            WE3    = ($urandom_range(0, 1) == 1);
            WA3    = AW'($urandom_range(0, NREG-1));
            WD3    = DW'($urandom);
            SB_SET = ($urandom_range(0, 2) == 0);
            SB_WA  = AW'($urandom_range(0, NREG-1));
            if (!stall) begin
                LD_VALID = ($urandom_range(0, 1) == 1);
                LD_WA    = AW'($urandom_range(0, NREG-1));
                LD_WD    = DW'($urandom);
            end
            stall = LD_VALID && WE3 && (WA3 == LD_WA);
            tick();
        end
        idle(); tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file for the multicycle processor, replacing the fixed 8x8 version.
- Two combinational read ports and one ALU write port (port 3).
- A second load-return write port with a valid/ready handshake.
- A per-register scoreboard of busy bits for outstanding loads, so the control FSM can stall on RAW hazards.
- A debug read port replaces the fixed per-register dump outputs.

Parameters:
DW, 8, data width in bits
NREG, 8, number of registers (power of two, >=4)
AW, $clog2(NREG), register address width
MAX_PEND, 2, maximum number of outstanding loads tracked by the pending counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
RA1  in  AW  read address port 1
RA2  in  AW  read address port 2
RD1  out  DW  read data port 1
RD2  out  DW  read data port 2
BUSY1  out  1  busy bit of RA1
BUSY2  out  1  busy bit of RA2
WE3  in  1  ALU write enable
WA3  in  AW  ALU write address
WD3  in  DW  ALU write data
LD_VALID  in  1  load-return data valid
LD_RDY  out  1  load-return port ready
LD_WA  in  AW  load-return address
LD_WD  in  DW  load-return data
SB_SET  in  1  mark SB_WA busy (load issued)
SB_WA  in  AW  address to mark busy
PEND  out  $clog2(MAX_PEND+1)  outstanding load count
PEND_FULL  out  1  PEND == MAX_PEND
ERR  out  1  sticky scoreboard protocol error
DBG_RA  in  AW  debug read address
DBG_RD  out  DW  debug read data

Behaviour:
- Reset: RST synchronous, active-high, dominates every other input in the same cycle.
  - Cleared on reset: all NREG registers, all busy bits, PEND and ERR, all to 0.
  - Outputs after reset: RD1/RD2/DBG_RD read 0; LD_RDY = 1.
- Reads:
  - RD1, RD2, DBG_RD, BUSY1 and BUSY2 are combinational from the current state.
  - Without bypass, a write is visible the cycle after the write edge.
- ALU write: if WE3 = 1, RF[WA3] <= WD3 at the rising edge. WE3 does not change busy bits.
- Load-return handshake:
  - A transfer occurs at a rising edge when LD_VALID = 1 and LD_RDY = 1.
  - LD_RDY = !(WE3 && WA3 == LD_WA). On a same-address collision the ALU write wins and the load stalls one cycle.
  - While LD_VALID = 1 and LD_RDY = 0, the source holds LD_WA and LD_WD stable.
  - A transfer writes RF[LD_WA] <= LD_WD, clears busy[LD_WA] and decrements PEND.
  - Different-address ALU and load writes in the same cycle both complete.
- Scoreboard set:
  - SB_SET with busy[SB_WA] = 0 and PEND_FULL = 0 sets busy[SB_WA] and increments PEND.
  - SB_SET with PEND_FULL = 1 is ignored and sets ERR.
  - SB_SET to an already-busy address is ignored and sets ERR.
- Simultaneous set and clear:
  - Same address (SB_SET together with a load transfer to that address): busy stays 1 and PEND is unchanged (net +1 -1).
  - Different addresses: both apply, PEND net 0.
- Load transfer to a non-busy address: data is written, PEND unchanged (no underflow), ERR set.
- ERR is sticky until RST.
- PEND never exceeds MAX_PEND and never wraps below 0.

Optional Feature:
REG_FILE_BYPASS_EN.
- Defined: write-first forwarding.
  - RD1/RD2/DBG_RD return WD3 when WE3 = 1 and the read address equals WA3.
  - Otherwise they return LD_WD when a load transfer targets that address.
  - ALU forwarding has priority over load forwarding.
  - BUSY1/BUSY2 read 0 when a load transfer to that address occurs in the same cycle.
- Undefined: reads return stored state only, with one-cycle write-to-read latency.

Decomposition:
- Package reg_file_pkg holds:
  - default DW, NREG and MAX_PEND constants;
  - typedef reg_addr_t = logic [AW-1:0];
  - typedef reg_data_t = logic [DW-1:0].
- Sub-module reg_file_scoreboard: busy vector, PEND counter, PEND_FULL and ERR logic, taking set/clear strobes.
- The top level holds the storage array, read muxes, LD_RDY arbitration and bypass.

Test Plan:
- Reset: RST = 1 for 1 cycle after writing 8'hAA to R3 -> RD1 (RA1 = 3) = 0, PEND = 0, ERR = 0, LD_RDY = 1.
- ALU write: WE3 = 1, WA3 = 5, WD3 = 8'h3C -> without bypass RD1 (RA1 = 5) = 8'h3C next cycle; with REG_FILE_BYPASS_EN, 8'h3C in the same cycle.
- Load flow: SB_SET on R2 -> BUSY1 (RA1 = 2) = 1, PEND = 1. Then LD_VALID, LD_WA = 2, LD_WD = 8'h7E -> BUSY1 = 0, PEND = 0, RD1 = 8'h7E.
- Collision: WE3 with WA3 = 4, WD3 = 8'h11, and LD_VALID with LD_WA = 4, LD_WD = 8'h22 in the same cycle:
  - that cycle: LD_RDY = 0 and the ALU write is applied;
  - next cycle: the load completes and R4 = 8'h22.
- Pending overflow: SB_SET on R1, then R2 (PEND = 2, PEND_FULL = 1), then SB_SET on R3 -> R3 not busy, PEND = 2, ERR = 1 until RST.
- Same-address set/clear: R6 busy, PEND = 1; a load transfer to R6 and SB_SET on R6 in one cycle -> busy[6] = 1, PEND = 1, R6 = LD_WD.
